// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port around mem_port_arbiter.
// master = the arbiter; slave = the CPU and memory side that drives requests and read data.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wmask;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic              m_rstrb;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wmask;
  logic [31:0]       m_rdata;

  logic              busy;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_rstrb, m_wdata, m_wmask, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_rstrb, m_wdata, m_wmask, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch (I) and load/store (D)
// paths; one transaction in flight, read data returned with a one-cycle valid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

  state_t            state_reg;
  logic              winner_d_reg;
  logic              last_d_reg;
  logic [2:0]        cnt_reg;
  logic              i_gnt_reg;
  logic              d_gnt_reg;
  logic              i_rvalid_reg;
  logic              d_rvalid_reg;
  logic [ADDR_W-1:0] m_addr_reg;
  logic              m_rstrb_reg;
  logic [31:0]       m_wdata_reg;
  logic [3:0]        m_wmask_reg;

  // D wins when it is the only requester, or on a tie when I was served last.
  logic pick_d;
  assign pick_d = bus.d_req && (!bus.i_req || !last_d_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      winner_d_reg <= 1'b0;
      last_d_reg   <= 1'b1;
      cnt_reg      <= 3'd0;
      i_gnt_reg    <= 1'b0;
      d_gnt_reg    <= 1'b0;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      m_addr_reg   <= '0;
      m_rstrb_reg  <= 1'b0;
      m_wdata_reg  <= 32'd0;
      m_wmask_reg  <= 4'd0;
    end else begin
      i_gnt_reg    <= 1'b0;
      d_gnt_reg    <= 1'b0;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            state_reg <= ISSUE;
            if (pick_d) begin
              m_addr_reg   <= bus.d_addr;
              m_wdata_reg  <= bus.d_wdata;
              m_wmask_reg  <= bus.d_wmask;
              m_rstrb_reg  <= (bus.d_wmask == 4'd0);
              d_gnt_reg    <= 1'b1;
              winner_d_reg <= 1'b1;
              last_d_reg   <= 1'b1;
            end else begin
              m_addr_reg   <= bus.i_addr;
              m_wdata_reg  <= 32'd0;
              m_wmask_reg  <= 4'd0;
              m_rstrb_reg  <= 1'b1;
              i_gnt_reg    <= 1'b1;
              winner_d_reg <= 1'b0;
              last_d_reg   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          m_rstrb_reg <= 1'b0;
          m_wmask_reg <= 4'd0;
          if (m_wmask_reg != 4'd0) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= WAIT;
            cnt_reg   <= CNT_INIT;
            // With a single-cycle memory the first WAIT cycle already carries the data.
            if (RD_LATENCY == 1) begin
              i_rvalid_reg <= !winner_d_reg;
              d_rvalid_reg <= winner_d_reg;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
            if (cnt_reg == 3'd1) begin
              i_rvalid_reg <= !winner_d_reg;
              d_rvalid_reg <= winner_d_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.i_gnt    = i_gnt_reg;
  assign bus.d_gnt    = d_gnt_reg;
  assign bus.i_rvalid = i_rvalid_reg;
  assign bus.d_rvalid = d_rvalid_reg;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign bus.m_addr   = m_addr_reg;
  assign bus.m_rstrb  = m_rstrb_reg;
  assign bus.m_wdata  = m_wdata_reg;
  assign bus.m_wmask  = m_wmask_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule
